sram_d_arbiter: RTL and testbench
=================================

Name: sram_d_arbiter

Overview:
Two-manager, one-subordinate OBI arbiter that shares the SRAM data port (sram_d_*) between the core data port (m0) and a DMA/debug manager (m1). Arbitration is round-robin. Each granted transaction's manager ID is pushed into an outstanding-ID FIFO, so every rvalid/rdata response returns to the manager that issued it. The block sits directly in front of the SRAM wrapper's sram_d interface.

Parameters:
MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO (1..4); caps accepted-but-unanswered transactions.
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the occupancy counter (derived; do not override).

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
m0_req_i / m1_req_i  input  1  manager request
m0_gnt_o / m1_gnt_o  output  1  manager grant
m0_addr_i / m1_addr_i  input  32  byte address
m0_we_i / m1_we_i  input  1  write enable
m0_be_i / m1_be_i  input  4  byte enables
m0_wdata_i / m1_wdata_i  input  32  write data
m0_rvalid_o / m1_rvalid_o  output  1  response valid
m0_rdata_o / m1_rdata_o  output  32  response data
s_req_o  output  1  request to SRAM data port
s_gnt_i  input  1  grant from SRAM data port
s_addr_o  output  32  muxed address
s_we_o  output  1  muxed write enable
s_be_o  output  4  muxed byte enables
s_wdata_o  output  32  muxed write data
s_rvalid_i  input  1  response valid from SRAM
s_rdata_i  input  32  response data from SRAM
err_o  output  1  sticky protocol error: rvalid with empty FIFO

Behaviour:
- Reset (async on rst_ni low): FIFO empty, count=0, rr_last=1 so m0 wins the first tie, err_o=0.
- While reset is asserted, all outputs are 0 (gnt, rvalid and s_req included). A reset mid-transaction drops the outstanding IDs; any late s_rvalid_i after reset raises err_o.
- can_issue = (count < MAX_OUTSTANDING) || s_rvalid_i. This means push and pop in the same cycle are allowed when the FIFO is full.
- Selection is combinational:
  - Only m0_req_i: select m0.
  - Only m1_req_i: select m1.
  - Both: select the manager != rr_last.
  - Neither, or !can_issue: no selection.
- Subordinate drive:
  - s_req_o = can_issue && (m0_req_i || m1_req_i).
  - s_addr_o, s_we_o, s_be_o, s_wdata_o come from the selected manager; all are 0 when there is no selection.
- Grant: mX_gnt_o = selected(X) && s_gnt_i. The non-selected manager's gnt is 0. Its req stays pending per OBI and it is reconsidered next cycle.
- Acceptance = s_req_o && s_gnt_i. On acceptance:
  - Push the selected ID into the FIFO.
  - rr_last <= selected ID.
- A non-accepted cycle leaves rr_last unchanged. The selection may change while s_gnt_i is low.
- Response: when s_rvalid_i=1 and count>0, pop the head ID and drive m<head>_rvalid_o=1 and m<head>_rdata_o=s_rdata_i in the same cycle (combinational). The other manager gets rvalid=0 and rdata=0.
- When s_rvalid_i=1 and count==0: no manager receives rvalid, no pop occurs, err_o<=1 and stays set until reset.
- Count update: push only → +1; pop only → −1; both → unchanged.
- Pointers wrap modulo MAX_OUTSTANDING. Count never exceeds MAX_OUTSTANDING and never goes below 0.
- Responses return in order (the SRAM is in-order with 1-cycle latency). Throughput is 1 transaction/cycle sustained with MAX_OUTSTANDING≥1, given the rvalid bypass.
- Fairness: with both managers requesting continuously and s_gnt_i=1, grants alternate m0, m1, m0, … No starvation beyond 1 lost arbitration.

Test Plan:
- Reset then single m0 read: m0 req addr 0x8000_0010, s_gnt=1, SRAM returns 0xDEADBEEF next cycle → m0_gnt=1 in cycle 0, m0_rvalid=1 with rdata 0xDEADBEEF in cycle 1, m1_rvalid=0 throughout.
- Both request continuously for 6 cycles, s_gnt=1, 1-cycle rvalid → grant order m0,m1,m0,m1,m0,m1; rvalid routed in the same order with the correct rdata. m1 write (we=1, be=4'b0011, wdata 0x1234_5678) appears unchanged on the s_* ports in its granted cycle.
- MAX_OUTSTANDING=2, s_gnt=1, rvalid withheld for 3 cycles → 2 acceptances, then s_req_o=0 and both gnt=0 until rvalid. When rvalid arrives, a new grant is issued in that same cycle.
- s_gnt_i held 0 for 4 cycles with both requesting → no pushes, rr_last unchanged, and m0 (after reset) is granted first when s_gnt_i rises.
- Spurious s_rvalid_i with count=0 → no mX_rvalid_o, err_o=1 from next cycle and sticky, count stays 0.
- Assert rst_ni low with 2 outstanding → outputs 0 immediately, count=0. A subsequent rvalid sets err_o; the next m1 request is granted normally.

Source files
------------

// File: rtl/sram_d_arbiter.sv
// Round-robin OBI arbiter sharing the SRAM data port between the core (m0) and a DMA/debug manager (m1).
// An outstanding-ID FIFO sends each in-order response back to the manager that issued the request.
module sram_d_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        m0_req_i,
   output logic        m0_gnt_o,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   output logic        m1_gnt_o,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,
   output logic        s_req_o,
   input  logic        s_gnt_i,
   output logic [31:0] s_addr_o,
   output logic        s_we_o,
   output logic [3:0]  s_be_o,
   output logic [31:0] s_wdata_o,
   input  logic        s_rvalid_i,
   input  logic [31:0] s_rdata_i,
   output logic        err_o
);

   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

   logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic                       rr_last_q, rr_last_d;
   logic                       err_q, err_d;

   logic can_issue;
   logic sel_valid;
   logic sel_id;
   logic accept;
   logic pop;
   logic head_id;

   // A response arriving this cycle frees a slot, so a full FIFO can still accept a new request.
   always_comb begin
      can_issue = (count_q < MAX_CNT) || s_rvalid_i;
      sel_valid = 1'b0;
      sel_id    = 1'b0;
      if (rst_ni && can_issue) begin
         if (m0_req_i && m1_req_i) begin
            sel_valid = 1'b1;
            sel_id    = ~rr_last_q;
         end else if (m0_req_i) begin
            sel_valid = 1'b1;
            sel_id    = 1'b0;
         end else if (m1_req_i) begin
            sel_valid = 1'b1;
            sel_id    = 1'b1;
         end
      end
   end

   assign accept  = sel_valid && s_gnt_i;
   assign pop     = rst_ni && s_rvalid_i && (count_q != '0);
   assign head_id = fifo_q[rd_ptr_q];

   always_comb begin
      s_req_o   = sel_valid;
      s_addr_o  = '0;
      s_we_o    = 1'b0;
      s_be_o    = '0;
      s_wdata_o = '0;
      if (sel_valid && !sel_id) begin
         s_addr_o  = m0_addr_i;
         s_we_o    = m0_we_i;
         s_be_o    = m0_be_i;
         s_wdata_o = m0_wdata_i;
      end else if (sel_valid && sel_id) begin
         s_addr_o  = m1_addr_i;
         s_we_o    = m1_we_i;
         s_be_o    = m1_be_i;
         s_wdata_o = m1_wdata_i;
      end
   end

   always_comb begin
      m0_gnt_o    = accept && !sel_id;
      m1_gnt_o    = accept && sel_id;
      m0_rvalid_o = pop && !head_id;
      m1_rvalid_o = pop && head_id;
      m0_rdata_o  = (pop && !head_id) ? s_rdata_i : '0;
      m1_rdata_o  = (pop && head_id) ? s_rdata_i : '0;
      err_o       = err_q;
   end

   always_comb begin
      fifo_d    = fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rr_last_d = rr_last_q;
      err_d     = err_q;
      if (accept) begin
         fifo_d[wr_ptr_q] = sel_id;
         wr_ptr_d         = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
         rr_last_d        = sel_id;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (accept && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!accept && pop) begin
         count_d = count_q - CNT_W'(1);
      end
      // A response with nothing outstanding is a protocol violation by the subordinate.
      if (s_rvalid_i && (count_q == '0)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rr_last_q <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         fifo_q    <= fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rr_last_q <= rr_last_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Scoreboard bench for sram_d_arbiter: stimulus predicts grants and bus contents per cycle,
// and a negedge monitor matches responses against the queue of issuing managers.
module tb_sram_d_arbiter;

   localparam int unsigned MAX = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        m0_req_i, m1_req_i;
   logic        m0_gnt_o, m1_gnt_o;
   logic [31:0] m0_addr_i, m1_addr_i;
   logic        m0_we_i, m1_we_i;
   logic [3:0]  m0_be_i, m1_be_i;
   logic [31:0] m0_wdata_i, m1_wdata_i;
   logic        m0_rvalid_o, m1_rvalid_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        s_req_o, s_gnt_i;
   logic [31:0] s_addr_o;
   logic        s_we_o;
   logic [3:0]  s_be_o;
   logic [31:0] s_wdata_o;
   logic        s_rvalid_i;
   logic [31:0] s_rdata_i;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   sram_d_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
      .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
      .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
      .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
      .err_o(err_o)
   );

   typedef struct {
      logic        rst_n, req0, req1, we0, we1, gnt, rvalid;
      logic [31:0] addr0, addr1, wdata0, wdata1, rdata;
      logic [3:0]  be0, be1;
   } stim_t;

   typedef struct {
      logic        s_req, gnt0, gnt1, we;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
   } exp_t;

   exp_t cyc_q[$];
   int   resp_q[$];
   int   compared = 0;
   int   mismatched = 0;
   logic rr_last_m = 1'b1;
   logic err_m = 1'b0;

   exp_t        mon_e;
   int          mon_id;
   logic [65:0] mon_rsp;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t idle_stim();
      stim_t s;
      s.rst_n = 1'b1; s.req0 = 1'b0; s.req1 = 1'b0; s.we0 = 1'b0; s.we1 = 1'b0;
      s.gnt = 1'b0; s.rvalid = 1'b0; s.addr0 = '0; s.addr1 = '0; s.wdata0 = '0;
      s.wdata1 = '0; s.rdata = '0; s.be0 = '0; s.be1 = '0;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s = idle_stim();
      s.req0   = ($urandom_range(0, 9) < 7);
      s.req1   = ($urandom_range(0, 9) < 6);
      s.we0    = 1'($urandom);
      s.we1    = 1'($urandom);
      s.addr0  = $urandom;
      s.addr1  = $urandom;
      s.wdata0 = $urandom;
      s.wdata1 = $urandom;
      s.be0    = 4'($urandom);
      s.be1    = 4'($urandom);
      s.rdata  = $urandom;
      s.gnt    = ($urandom_range(0, 3) != 0);
      return s;
   endfunction

   // Drive one cycle, predict the request side from the arbitration rules, then record any acceptance.
   task automatic applyStimulus(input stim_t s);
      exp_t e;
      int   win;
      logic can_issue;
      @(posedge clk_i);
      #1;
      rst_ni = s.rst_n; m0_req_i = s.req0; m1_req_i = s.req1;
      m0_addr_i = s.addr0; m1_addr_i = s.addr1; m0_we_i = s.we0; m1_we_i = s.we1;
      m0_be_i = s.be0; m1_be_i = s.be1; m0_wdata_i = s.wdata0; m1_wdata_i = s.wdata1;
      s_gnt_i = s.gnt; s_rvalid_i = s.rvalid; s_rdata_i = s.rdata;
      e = '{s_req: 1'b0, gnt0: 1'b0, gnt1: 1'b0, we: 1'b0, addr: '0, wdata: '0, be: '0};
      can_issue = (resp_q.size() < MAX) || s.rvalid;
      win = -1;
      if (s.rst_n && can_issue) begin
         if (s.req0 && s.req1) win = (rr_last_m == 1'b1) ? 0 : 1;
         else if (s.req0)      win = 0;
         else if (s.req1)      win = 1;
      end
      if (win == 0) begin
         e.s_req = 1'b1; e.gnt0 = s.gnt;
         e.addr = s.addr0; e.we = s.we0; e.be = s.be0; e.wdata = s.wdata0;
      end else if (win == 1) begin
         e.s_req = 1'b1; e.gnt1 = s.gnt;
         e.addr = s.addr1; e.we = s.we1; e.be = s.be1; e.wdata = s.wdata1;
      end
      cyc_q.push_back(e);
      @(negedge clk_i);
      #1;
      if (!s.rst_n) begin
         rr_last_m = 1'b1;
      end else if (win >= 0 && s.gnt) begin
         rr_last_m = win[0];
         resp_q.push_back(win);
      end
   endtask

   task automatic do_reset(input int cycles, input logic with_traffic);
      stim_t s;
      s = idle_stim();
      s.rst_n = 1'b0;
      if (with_traffic) begin
         s.req0 = 1'b1; s.req1 = 1'b1; s.gnt = 1'b1; s.rvalid = 1'b1; s.rdata = 32'hCAFE_F00D;
      end
      repeat (cycles) applyStimulus(s);
   endtask

   always @(negedge clk_i) begin
      if (cyc_q.size() > 0) begin
         mon_e = cyc_q.pop_front();
         checkOutput("grant", 128'({s_req_o, m0_gnt_o, m1_gnt_o}),
                     128'({mon_e.s_req, mon_e.gnt0, mon_e.gnt1}));
         checkOutput("s_bus", 128'({s_addr_o, s_we_o, s_be_o, s_wdata_o}),
                     128'({mon_e.addr, mon_e.we, mon_e.be, mon_e.wdata}));
      end
      if (!rst_ni) begin
         checkOutput("reset_rsp", 128'({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o, err_o}), '0);
         resp_q.delete();
         err_m = 1'b0;
      end else begin
         checkOutput("err", 128'(err_o), 128'(err_m));
         mon_rsp = '0;
         if (s_rvalid_i && resp_q.size() > 0) begin
            mon_id = resp_q.pop_front();
            if (mon_id == 0) mon_rsp = {1'b1, 1'b0, s_rdata_i, 32'h0};
            else             mon_rsp = {1'b0, 1'b1, 32'h0, s_rdata_i};
         end else if (s_rvalid_i) begin
            err_m = 1'b1;
         end
         checkOutput("response", 128'({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o}), 128'(mon_rsp));
      end
   end

   initial begin
      stim_t s;
      rst_ni = 1'b0; m0_req_i = 1'b0; m1_req_i = 1'b0; m0_addr_i = '0; m1_addr_i = '0;
      m0_we_i = 1'b0; m1_we_i = 1'b0; m0_be_i = '0; m1_be_i = '0; m0_wdata_i = '0; m1_wdata_i = '0;
      s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;

      do_reset(2, 1'b1);

      s = idle_stim(); s.req0 = 1'b1; s.addr0 = 32'h8000_0010; s.gnt = 1'b1;
      applyStimulus(s);
      s = idle_stim(); s.rvalid = 1'b1; s.rdata = 32'hDEAD_BEEF;
      applyStimulus(s);

      do_reset(1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         s = idle_stim(); s.req0 = 1'b1; s.req1 = 1'b1; s.gnt = 1'b1;
         s.addr0 = $urandom; s.wdata0 = $urandom; s.be0 = 4'hF;
         s.addr1 = $urandom; s.we1 = 1'b1; s.be1 = 4'b0011; s.wdata1 = 32'h1234_5678;
         s.rvalid = (i > 0); s.rdata = $urandom;
         applyStimulus(s);
      end
      s = idle_stim(); s.rvalid = 1'b1; s.rdata = $urandom;
      applyStimulus(s);

      do_reset(1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         s = idle_stim(); s.req0 = 1'b1; s.req1 = 1'b1; s.gnt = 1'b1;
         s.addr0 = $urandom; s.addr1 = $urandom; s.rvalid = (i == 3); s.rdata = $urandom;
         applyStimulus(s);
      end
      for (int i = 0; i < 2; i++) begin
         s = idle_stim(); s.rvalid = 1'b1; s.rdata = $urandom;
         applyStimulus(s);
      end

      do_reset(1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         s = idle_stim(); s.req0 = 1'b1; s.req1 = 1'b1; s.gnt = (i == 4);
         s.addr0 = 32'h0000_1000; s.addr1 = 32'h0000_2000;
         applyStimulus(s);
      end
      s = idle_stim(); s.rvalid = 1'b1; s.rdata = $urandom;
      applyStimulus(s);

      s = idle_stim(); s.rvalid = 1'b1; s.rdata = 32'h5555_AAAA;
      applyStimulus(s);
      s = idle_stim();
      repeat (2) applyStimulus(s);

      for (int i = 0; i < 2; i++) begin
         s = idle_stim(); s.req0 = 1'b1; s.gnt = 1'b1; s.addr0 = $urandom;
         applyStimulus(s);
      end
      do_reset(1, 1'b1);
      s = idle_stim(); s.rvalid = 1'b1; s.rdata = $urandom;
      applyStimulus(s);
      s = idle_stim(); s.req1 = 1'b1; s.gnt = 1'b1; s.addr1 = 32'h0000_0040;
      applyStimulus(s);
      s = idle_stim(); s.rvalid = 1'b1; s.rdata = $urandom;
      applyStimulus(s);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset($urandom_range(1, 2), 1'($urandom));
         end else begin
            s = rand_stim();
            if (resp_q.size() > 0) s.rvalid = ($urandom_range(0, 9) < 7);
            else                   s.rvalid = ($urandom_range(0, 99) == 0);
            applyStimulus(s);
         end
      end

      s = idle_stim();
      applyStimulus(s);
      @(negedge clk_i);
      #1;
      checkOutput("cycle_queue_drained", 128'(cyc_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
